// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle LEGv8-style controller.
// Macro MULTICYCLE_BRANCH_EN adds the BRANCH and JUMP states.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7
`ifdef MULTICYCLE_BRANCH_EN
    ,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
`endif
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_CBZ     = 3'd3,
    CLS_B       = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // CBZ and B are matched on their fixed prefix only.
  localparam logic [7:0] OP_CBZ_PREFIX = 8'b10110100;
  localparam logic [5:0] OP_B_PREFIX   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier; R-type matches win over all other patterns.
// Macro MULTICYCLE_BRANCH_EN enables the CBZ and B classes.
module opcode_class_decode
  import multicycle_control_pkg::*;
(
  input  logic [10:0] opcode_i,
  output op_class_e   op_class_o
);

  always_comb begin
    op_class_o = CLS_ILLEGAL;
    if (opcode_i == OP_ADD || opcode_i == OP_SUB ||
        opcode_i == OP_AND || opcode_i == OP_ORR) begin
      op_class_o = CLS_RTYPE;
    end else if (opcode_i == OP_LDUR) begin
      op_class_o = CLS_LOAD;
    end else if (opcode_i == OP_STUR) begin
      op_class_o = CLS_STORE;
`ifdef MULTICYCLE_BRANCH_EN
    end else if (opcode_i[10:3] == OP_CBZ_PREFIX) begin
      op_class_o = CLS_CBZ;
    end else if (opcode_i[10:5] == OP_B_PREFIX) begin
      op_class_o = CLS_B;
`endif
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: FSM, control decode and retired-instruction counter.
// Macro MULTICYCLE_BRANCH_EN adds CBZ/B execution; otherwise those opcodes are illegal.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic        mem_ready,
  output logic [1:0]  ALUOp,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        Reg2Loc,
  output logic        ALUSrcA,
  output logic        PCSource,
  output logic [1:0]  ALUSrcB,
  output logic        illegal,
  output logic [31:0] instr_count,
  output logic [3:0]  state
);

  state_e      state_q, state_d;
  op_class_e   op_class;
  logic [31:0] count_q, count_d;
  logic        retire;

  opcode_class_decode u_decode (
    .opcode_i   (opcode),
    .op_class_o (op_class)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign count_d = count_q + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
  assign state       = state_q;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    ALUOp       = ALUOP_ADD;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    Reg2Loc     = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = 1'b0;
    ALUSrcB     = SRCB_REG;
    illegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // Reset holds the FSM in FETCH; keep it from writing IR/PC meanwhile.
        IRWrite = mem_ready & ~rst;
        PCWrite = mem_ready & ~rst;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BROFF;
        case (op_class)
          CLS_RTYPE:            state_d = S_R_EXEC;
          CLS_LOAD, CLS_STORE:  state_d = S_MEM_ADDR;
`ifdef MULTICYCLE_BRANCH_EN
          CLS_CBZ:              state_d = S_BRANCH;
          CLS_B:                state_d = S_JUMP;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (op_class == CLS_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        ALUOp   = ALUOP_RTYPE;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
`ifdef MULTICYCLE_BRANCH_EN
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_PASSB;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        Reg2Loc     = 1'b1;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table plus reset and counter-wrap sequences.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] opcode;
  logic        mem_ready;
  logic [1:0]  ALUOp, ALUSrcB;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, Reg2Loc, ALUSrcA, PCSource, illegal;
  logic [31:0] instr_count;
  logic [3:0]  state;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .illegal(illegal), .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, Reg2Loc, ALUSrcA, PCSource;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    logic [3:0] st;
    ctrl_t      c;
  } exp_t;

  // seq holds one state per cycle, first cycle in the low nibble; mr bit i is mem_ready in cycle i.
  typedef struct {
    string       nm;
    logic [10:0] op;
    logic [7:0]  mr;
    logic [31:0] seq;
    int          len;
    int          dcnt;
    bit          ill;
  } vec_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_cnt;

  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr, input bit ill);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH:     begin c.MemRead = 1; c.ALUSrcB = 2'b01; c.IRWrite = mr; c.PCWrite = mr; end
      S_DECODE:    begin c.ALUSrcB = 2'b11; c.illegal = ill; end
      S_MEM_ADDR:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
      S_MEM_READ:  begin c.MemRead = 1; c.IorD = 1; end
      S_MEM_WB:    begin c.RegWrite = 1; c.MemtoReg = 1; end
      S_MEM_WRITE: begin c.MemWrite = 1; c.IorD = 1; c.Reg2Loc = 1; end
      S_R_EXEC:    begin c.ALUSrcA = 1; c.ALUOp = 2'b10; end
      S_R_WB:      begin c.RegWrite = 1; end
`ifdef MULTICYCLE_BRANCH_EN
      S_BRANCH:    begin c.ALUSrcA = 1; c.ALUOp = 2'b01; c.PCWriteCond = 1; c.PCSource = 1; c.Reg2Loc = 1; end
      S_JUMP:      begin c.PCWrite = 1; c.PCSource = 1; end
`endif
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_t act_ctrl();
    ctrl_t c;
    c = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
         MemtoReg, RegWrite, Reg2Loc, ALUSrcA, PCSource, ALUSrcB, ALUOp, illegal};
    return c;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Opcode is scrambled during FETCH cycles; the controller must ignore it there.
  task automatic run_cycle(input string nm, input logic [10:0] op, input logic mr,
                           input logic [3:0] st, input bit ill);
    exp_t e;
    @(negedge clk);
    opcode    = (st == S_FETCH) ? ~op : op;
    mem_ready = mr;
    e.st = st;
    e.c  = exp_ctrl(st, mr, ill);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check({nm, " state"}, {28'd0, state}, {28'd0, e.st});
    check({nm, " ctrl"}, {16'd0, act_ctrl()}, {16'd0, e.c});
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.len; i++)
      run_cycle(v.nm, v.op, v.mr[i], v.seq[4*i +: 4], v.ill);
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + v.dcnt;
    check({v.nm, " count"}, instr_count, exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{"ADD",  11'b10001011000, 8'hFF, 32'({S_R_WB, S_R_EXEC, S_DECODE, S_FETCH}), 4, 1, 0});
    vecs.push_back('{"SUB",  11'b11001011000, 8'hFF, 32'({S_R_WB, S_R_EXEC, S_DECODE, S_FETCH}), 4, 1, 0});
    vecs.push_back('{"AND",  11'b10001010000, 8'hFF, 32'({S_R_WB, S_R_EXEC, S_DECODE, S_FETCH}), 4, 1, 0});
    vecs.push_back('{"ORR",  11'b10101010000, 8'hFF, 32'({S_R_WB, S_R_EXEC, S_DECODE, S_FETCH}), 4, 1, 0});
    vecs.push_back('{"LDUR", 11'b11111000010, 8'hFF,
                     32'({S_MEM_WB, S_MEM_READ, S_MEM_ADDR, S_DECODE, S_FETCH}), 5, 1, 0});
    vecs.push_back('{"LDUR3W", 11'b11111000010, 8'b11000111,
                     32'({S_MEM_WB, S_MEM_READ, S_MEM_READ, S_MEM_READ, S_MEM_READ,
                          S_MEM_ADDR, S_DECODE, S_FETCH}), 8, 1, 0});
    vecs.push_back('{"STUR", 11'b11111000000, 8'hFF,
                     32'({S_MEM_WRITE, S_MEM_ADDR, S_DECODE, S_FETCH}), 4, 1, 0});
    vecs.push_back('{"STUR1W", 11'b11111000000, 8'b11110111,
                     32'({S_MEM_WRITE, S_MEM_WRITE, S_MEM_ADDR, S_DECODE, S_FETCH}), 5, 1, 0});
    vecs.push_back('{"ADDFW", 11'b10001011000, 8'b11111110,
                     32'({S_R_WB, S_R_EXEC, S_DECODE, S_FETCH, S_FETCH}), 5, 1, 0});
    vecs.push_back('{"ILL0", 11'b00000000000, 8'hFF, 32'({S_DECODE, S_FETCH}), 2, 0, 1});
`ifdef MULTICYCLE_BRANCH_EN
    vecs.push_back('{"CBZ", 11'b10110100101, 8'hFF, 32'({S_BRANCH, S_DECODE, S_FETCH}), 3, 1, 0});
    vecs.push_back('{"B",   11'b00010110101, 8'hFF, 32'({S_JUMP, S_DECODE, S_FETCH}), 3, 1, 0});
`else
    vecs.push_back('{"CBZ", 11'b10110100101, 8'hFF, 32'({S_DECODE, S_FETCH}), 2, 0, 1});
    vecs.push_back('{"B",   11'b00010110101, 8'hFF, 32'({S_DECODE, S_FETCH}), 2, 0, 1});
`endif
    vecs.push_back('{"ILL1", 11'b11111000001, 8'hFF, 32'({S_DECODE, S_FETCH}), 2, 0, 1});
    vecs.push_back('{"ADD2", 11'b10001011000, 8'hFF, 32'({S_R_WB, S_R_EXEC, S_DECODE, S_FETCH}), 4, 1, 0});

    // Reset: FETCH values with IR/PC writes suppressed even though mem_ready is high.
    rst = 1'b1; mem_ready = 1'b1; opcode = 11'b10001011000;
    #1;
    check("rst state", {28'd0, state}, {28'd0, S_FETCH});
    check("rst count", instr_count, 32'd0);
    check("rst ctrl", {16'd0, act_ctrl()}, {16'd0, exp_ctrl(S_FETCH, 1'b0, 0)});
    repeat (2) @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    exp_cnt = '0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while stalled in MEM_WRITE aborts the store immediately.
    run_cycle("RSTMW", 11'b11111000000, 1'b1, S_FETCH, 0);
    run_cycle("RSTMW", 11'b11111000000, 1'b1, S_DECODE, 0);
    run_cycle("RSTMW", 11'b11111000000, 1'b1, S_MEM_ADDR, 0);
    run_cycle("RSTMW", 11'b11111000000, 1'b0, S_MEM_WRITE, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rstmw state", {28'd0, state}, {28'd0, S_FETCH});
    check("rstmw memwrite", {31'd0, MemWrite}, 32'd0);
    check("rstmw count", instr_count, 32'd0);
    mem_ready = 1'b1;
    #1;
    check("rstmw irwrite", {30'd0, IRWrite, PCWrite}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    exp_cnt = '0;

    // Counter wrap: preload all-ones, retire one instruction.
    @(negedge clk);
    dut.count_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    run_vec(vecs[0]);
    check("wrap zero", instr_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high reset).
REQ-002 opcode  input  11  instruction[31:21] from the instruction register.
REQ-003 mem_ready  input  1  memory handshake; access completes in a cycle where it is high.
REQ-004 ALUOp  output  2  to ALU control: 00 add, 01 pass-B/zero-test, 10 R-type function.
REQ-005 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, Reg2Loc, ALUSrcA, PCSource  outputs  1 each  datapath controls.
REQ-006 ALUSrcB  output  2  00 regB, 01 constant 4, 10 sign-extended immediate, 11 branch offset shifted left 2.
REQ-007 illegal  output  1  one-cycle pulse on an unrecognised opcode.
REQ-008 instr_count  output  32  retired-instruction counter.
REQ-009 state  output  4  current FSM state code, for debug.

Function
REQ-010 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP; every control output not listed for a state SHALL be 0.
REQ-011 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0. IRWrite and PCWrite SHALL equal mem_ready. Hold while mem_ready=0. Go to DECODE when mem_ready=1.
REQ-012 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
- 10001011000, 11001011000, 10001010000, 10101010000 -> R_EXEC
- 11111000010 (LDUR) or 11111000000 (STUR) -> MEM_ADDR
- opcode[10:3]=10110100 (CBZ) -> BRANCH
- opcode[10:5]=000101 (B) -> JUMP
- otherwise -> FETCH with illegal=1
REQ-013 R-type (ADD/SUB/AND/ORR) decode SHALL take priority over other patterns.
REQ-014 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ for LDUR, MEM_WRITE for STUR.
REQ-015 MEM_READ: MemRead=1, IorD=1. Hold until mem_ready=1, then go to MEM_WB.
REQ-016 MEM_WB: RegWrite=1, MemtoReg=1. Go to FETCH.
REQ-017 MEM_WRITE: MemWrite=1, IorD=1, Reg2Loc=1. Hold until mem_ready=1, then go to FETCH.
REQ-018 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to R_WB.
REQ-019 R_WB: RegWrite=1, MemtoReg=0. Go to FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, Reg2Loc=1. Go to FETCH.
REQ-021 JUMP: PCWrite=1, PCSource=1. Go to FETCH.
REQ-022 Latency with mem_ready held high SHALL be: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3; each mem_ready=0 cycle adds one cycle.
REQ-023 instr_count SHALL increment by 1 on the clock edge leaving MEM_WB, MEM_WRITE, R_WB, BRANCH or JUMP toward FETCH. It SHALL wrap from FFFFFFFF to 0. Illegal opcodes SHALL NOT be counted.
REQ-024 opcode SHALL only be sampled in DECODE, MEM_ADDR and the states that follow it; changes to opcode in FETCH SHALL have no effect.

Reset
REQ-025 rst=1 SHALL immediately force state=FETCH, instr_count=0 and illegal=0, with no clock edge required.
REQ-026 While in reset, control outputs SHALL take FETCH values with IRWrite=PCWrite=0.
REQ-027 Reset asserted mid-instruction SHALL abort it: no count, and no write asserted after rst rises.

Configuration
REQ-028 With macro MULTICYCLE_BRANCH_EN defined, CBZ and B SHALL decode to BRANCH/JUMP as specified above.
REQ-029 Without MULTICYCLE_BRANCH_EN, the BRANCH and JUMP states SHALL be absent. CBZ/B opcodes SHALL take the illegal path, and PCWriteCond SHALL be tied 0.

Structure
REQ-030 A shared package/include SHALL hold: state encodings, the six opcode constants, the ALUOp codes (00/01/10) and the ALUSrcB codes.
REQ-031 Opcode classification (R-type/load/store/CBZ/B/illegal) SHALL be a combinational sub-module, opcode_class_decode. The FSM, output decode and counter SHALL stay in multicycle_control.

Verification
REQ-032 ADD: mem_ready=1, opcode=10001011000 -> states FETCH,DECODE,R_EXEC,R_WB. ALUOp=10 in R_EXEC, RegWrite=1 in R_WB, instr_count 0->1.
REQ-033 LDUR with 3 wait cycles in MEM_READ: opcode=11111000010 -> 8 cycles total. MemRead=IorD=1 throughout MEM_READ, MemtoReg=RegWrite=1 in MEM_WB.
REQ-034 CBZ: opcode=10110100xxx -> 3 cycles. ALUOp=01, PCWriteCond=1 in BRANCH. Without MULTICYCLE_BRANCH_EN -> illegal pulse in DECODE, count unchanged.
REQ-035 Illegal opcode=00000000000 -> illegal=1 for exactly one cycle, return to FETCH, instr_count unchanged.
REQ-036 Reset asserted in MEM_WRITE while mem_ready=0 -> state=FETCH and MemWrite=0 in the same cycle, instr_count=0.
REQ-037 Counter preset to FFFFFFFF via 2^32-1 B instructions (or a forced value) plus one more B -> instr_count=00000000.
